// File: rtl/reg_file_pkg.sv
// Shared types and default sizes for the parameterised register file.
// Clear FSM states and default WIDTH/DEPTH constants.
package reg_file_pkg;

   localparam int DEF_WIDTH = 8;
   localparam int DEF_DEPTH = 16;

   typedef enum logic {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } clr_state_t;

endpackage

// File: rtl/reg_file_clr_seq.sv
// Clear sequencer: walks the clear index from 1 to DEPTH-1, one per cycle.
// A clr_req seen while already clearing is ignored.
module reg_file_clr_seq
   import reg_file_pkg::*;
#(
   parameter  int DEPTH = DEF_DEPTH,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr_req,
   output logic          busy,
   output logic [AW-1:0] idx
);

   localparam logic [AW-1:0] FIRST = AW'(1);
   localparam logic [AW-1:0] LAST  = AW'(DEPTH - 1);

   clr_state_t    state, state_d;
   logic [AW-1:0] idx_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         idx   <= FIRST;
      end else begin
         state <= state_d;
         idx   <= idx_d;
      end
   end

   always_comb begin
      state_d = state;
      idx_d   = idx;
      unique case (state)
         IDLE: begin
            if (clr_req) begin
               state_d = CLEAR;
               idx_d   = FIRST;
            end
         end
         CLEAR: begin
            // Index parks at 1 on exit so it matches the reset state.
            if (idx == LAST) begin
               state_d = IDLE;
               idx_d   = FIRST;
            end else begin
               idx_d = idx + FIRST;
            end
         end
         default: begin
            state_d = IDLE;
            idx_d   = FIRST;
         end
      endcase
   end

   always_comb begin
      busy = (state == CLEAR);
   end

endmodule

// File: rtl/reg_file_param.sv
// Parameterised register file, reg 0 hardwired to zero, with sequenced clear.
// Define REG_FILE_BYPASS_EN for write-through forwarding on the read ports.
module reg_file_param
   import reg_file_pkg::*;
#(
   parameter  int WIDTH   = DEF_WIDTH,
   parameter  int DEPTH   = DEF_DEPTH,
   parameter  int NRD     = 2,
   parameter  int OUT_IDX = DEPTH - 1,
   localparam int AW      = $clog2(DEPTH)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NRD*AW-1:0]    ra,
   output logic [NRD*WIDTH-1:0] rd,
   input  logic                 we,
   input  logic [AW-1:0]        wa,
   input  logic [WIDTH-1:0]     wd,
   input  logic                 clr_req,
   output logic                 busy,
   output logic [WIDTH-1:0]     out_reg
);

   logic [WIDTH-1:0] mem    [DEPTH];
   logic [WIDTH-1:0] mem_nx [DEPTH];
   logic [AW-1:0]    clr_idx;
   logic             wr_ok;

   reg_file_clr_seq #(
      .DEPTH (DEPTH)
   ) u_clr_seq (
      .clk     (clk),
      .rst     (rst),
      .clr_req (clr_req),
      .busy    (busy),
      .idx     (clr_idx)
   );

   assign wr_ok = we && (wa != '0) && !busy;

   // Clear and write never coincide: writes are dropped while busy.
   always_comb begin
      mem_nx = mem;
      if (busy) begin
         mem_nx[clr_idx] = '0;
      end else if (wr_ok) begin
         mem_nx[wa] = wd;
      end
      mem_nx[0] = '0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
         out_reg <= '0;
      end else begin
         mem     <= mem_nx;
         out_reg <= mem_nx[OUT_IDX];
      end
   end

   for (genvar k = 0; k < NRD; k++) begin : g_rd
      logic [AW-1:0] a;
      assign a = ra[k*AW +: AW];
`ifdef REG_FILE_BYPASS_EN
      assign rd[k*WIDTH +: WIDTH] = (wr_ok && (a == wa)) ? wd : mem[a];
`else
      assign rd[k*WIDTH +: WIDTH] = mem[a];
`endif
   end

endmodule

// File: tb/tb_reg_file_param.sv
// Self-checking bench for reg_file_param against a behavioural array model.
// Build with or without REG_FILE_BYPASS_EN; expectations follow the macro.
module tb_reg_file_param;

   localparam int W  = 8;
   localparam int D  = 16;
   localparam int AW = 4;
`ifdef REG_FILE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst;
   logic [2*AW-1:0] ra;
   logic [2*W-1:0]  rd;
   logic          we;
   logic [AW-1:0] wa;
   logic [W-1:0]  wd;
   logic          clr_req;
   logic          busy;
   logic [W-1:0]  out_reg;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: register contents plus remaining clear cycles.
   logic [W-1:0] m [D];
   int           clr_left;
   int           clr_next;

   always #5 clk = ~clk;

   reg_file_param dut (
      .clk     (clk),
      .rst     (rst),
      .ra      (ra),
      .rd      (rd),
      .we      (we),
      .wa      (wa),
      .wd      (wd),
      .clr_req (clr_req),
      .busy    (busy),
      .out_reg (out_reg)
   );

   function automatic logic [W-1:0] rd0();
      return rd[W-1:0];
   endfunction

   function automatic logic [W-1:0] rd1();
      return rd[2*W-1:W];
   endfunction

   function automatic logic [W-1:0] exp_rd(input logic [AW-1:0] a);
      if (BYP && we && wa != 0 && clr_left == 0 && a == wa) return wd;
      return m[a];
   endfunction

   task automatic model_reset();
      for (int i = 0; i < D; i++) m[i] = '0;
      clr_left = 0;
      clr_next = 1;
   endtask

   // Advance model with current inputs, then clock the DUT.
   task automatic step();
      bit wr;
      wr = we && wa != 0 && clr_left == 0;
      if (clr_left > 0) begin
         m[clr_next] = '0;
         clr_next++;
         clr_left--;
      end else if (clr_req) begin
         clr_left = D - 1;
         clr_next = 1;
      end
      if (wr) m[wa] = wd;
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      we = 0; wa = '0; wd = '0; clr_req = 0; ra = '0;
   endtask

   task automatic write(input int a, input int v);
      we = 1; wa = AW'(a); wd = W'(v);
      step();
      we = 0;
   endtask

   task automatic test_reset();
      idle_inputs();
      rst = 1;
      model_reset();
      #12;
      n_tests++;
      if (busy !== 1'b0) begin
         n_fail++; $display("FAIL reset_busy got %0b want 0", busy);
      end
      n_tests++;
      if (out_reg !== 8'h00) begin
         n_fail++; $display("FAIL reset_out got %h want 00", out_reg);
      end
      for (int i = 0; i < D; i++) begin
         ra = 8'(i);
         #1;
         n_tests++;
         if (rd0() !== 8'h00) begin
            n_fail++; $display("FAIL reset_reg%0d got %h want 00", i, rd0());
         end
      end
      @(negedge clk);
      rst = 0;
   endtask

   task automatic test_basic();
      write(5, 8'hA5);
      ra = {4'd0, 4'd5};
      #1;
      n_tests++;
      if (rd0() !== 8'hA5) begin
         n_fail++; $display("FAIL basic_rd0 got %h want a5", rd0());
      end
      n_tests++;
      if (rd1() !== 8'h00) begin
         n_fail++; $display("FAIL basic_rd1 got %h want 00", rd1());
      end
   endtask

   task automatic test_zero_write();
      write(0, 8'hFF);
      ra = {4'd0, 4'd0};
      #1;
      n_tests++;
      if (rd0() !== 8'h00) begin
         n_fail++; $display("FAIL zero_write got %h want 00", rd0());
      end
   endtask

   task automatic test_out_reg();
      write(15, 8'h3C);
      n_tests++;
      if (out_reg !== 8'h3C) begin
         n_fail++; $display("FAIL out_reg got %h want 3c", out_reg);
      end
      n_tests++;
      if (busy !== 1'b0) begin
         n_fail++; $display("FAIL out_busy got %0b want 0", busy);
      end
   endtask

   task automatic fill_index();
      for (int i = 1; i < D; i++) write(i, i);
   endtask

   task automatic test_clear();
      int cyc;
      fill_index();
      clr_req = 1;
      step();
      clr_req = 0;
      cyc = 0;
      while (busy === 1'b1 && cyc < 40) begin
         if (cyc == 3) begin
            ra = {4'd4, 4'd3};
            #1;
            n_tests++;
            if (rd0() !== 8'h00) begin
               n_fail++; $display("FAIL clr_reg3 got %h want 00", rd0());
            end
            n_tests++;
            if (rd1() !== 8'h04) begin
               n_fail++; $display("FAIL clr_reg4 got %h want 04", rd1());
            end
         end
         if (cyc == 5) begin
            we = 1; wa = 4'd2; wd = 8'hEE; clr_req = 1;
         end
         if (cyc == 6) begin
            ra = {4'd0, 4'd2};
            #1;
            n_tests++;
            if (rd0() !== m[2] || rd0() !== 8'h00) begin
               n_fail++; $display("FAIL clr_drop got %h want 00", rd0());
            end
         end
         step();
         we = 0; clr_req = 0;
         cyc++;
      end
      n_tests++;
      if (cyc != D - 1) begin
         n_fail++; $display("FAIL clr_len got %0d want %0d", cyc, D - 1);
      end
      for (int i = 0; i < D; i++) begin
         ra = 8'(i);
         #1;
         n_tests++;
         if (rd0() !== 8'h00) begin
            n_fail++; $display("FAIL clr_end_reg%0d got %h want 00", i, rd0());
         end
      end
   endtask

   task automatic test_rst_mid();
      fill_index();
      clr_req = 1;
      step();
      clr_req = 0;
      step(); step(); step();
      #2;
      rst = 1;
      model_reset();
      #1;
      n_tests++;
      if (busy !== 1'b0) begin
         n_fail++; $display("FAIL rstmid_busy got %0b want 0", busy);
      end
      for (int i = 0; i < D; i++) begin
         ra = 8'(i);
         #1;
         n_tests++;
         if (rd0() !== 8'h00) begin
            n_fail++; $display("FAIL rstmid_reg%0d got %h want 00", i, rd0());
         end
      end
      @(negedge clk);
      rst = 0;
      write(6, 8'h66);
      ra = {4'd0, 4'd6};
      #1;
      n_tests++;
      if (rd0() !== 8'h66) begin
         n_fail++; $display("FAIL rstmid_write got %h want 66", rd0());
      end
   endtask

   task automatic test_bypass();
      logic [W-1:0] want;
      write(7, 8'h11);
      we = 1; wa = 4'd7; wd = 8'h5A; ra = {4'd0, 4'd7};
      #1;
      want = BYP ? 8'h5A : 8'h11;
      n_tests++;
      if (rd0() !== want) begin
         n_fail++; $display("FAIL bypass_pre got %h want %h", rd0(), want);
      end
      step();
      we = 0;
      n_tests++;
      if (rd0() !== 8'h5A) begin
         n_fail++; $display("FAIL bypass_post got %h want 5a", rd0());
      end
      we = 1; wa = 4'd0; wd = 8'hFF; ra = {4'd0, 4'd0};
      #1;
      n_tests++;
      if (rd0() !== 8'h00) begin
         n_fail++; $display("FAIL bypass_zero got %h want 00", rd0());
      end
      step();
      we = 0;
   endtask

   task automatic test_random();
      logic [AW-1:0] a0, a1;
      for (int it = 0; it < 400; it++) begin
         we      = ($urandom_range(0, 2) != 0);
         wa      = AW'($urandom);
         wd      = W'($urandom);
         clr_req = ($urandom_range(0, 39) == 0);
         a0      = AW'($urandom);
         a1      = ($urandom_range(0, 3) == 0) ? a0 : AW'($urandom);
         if ($urandom_range(0, 3) == 0) a0 = wa;
         ra = {a1, a0};
         #1;
         n_tests++;
         if (rd0() !== exp_rd(a0) || rd1() !== exp_rd(a1)) begin
            n_fail++;
            $display("FAIL rand_rd it%0d got %h/%h want %h/%h",
                     it, rd0(), rd1(), exp_rd(a0), exp_rd(a1));
         end
         step();
         n_tests++;
         if (busy !== (clr_left > 0) || out_reg !== m[D-1]) begin
            n_fail++;
            $display("FAIL rand_state it%0d busy %0b/%0b out %h/%h",
                     it, busy, clr_left > 0, out_reg, m[D-1]);
         end
      end
      idle_inputs();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_zero_write();
      test_out_reg();
      test_clear();
      test_rst_mid();
      test_bypass();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
